// File: rtl/pwm_peripheral.sv
// 16-pin PWM/static output block driven by SPI-domain config registers.
// Optional feature macro: PWM_SHADOW_EN (duty held in a period-aligned shadow register).
module pwm_peripheral #(
  parameter int CLK_DIV = 13,
  parameter int DIV_W   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  en_reg_out_7_0,
  input  logic [7:0]  en_reg_out_15_8,
  input  logic [7:0]  en_reg_pwm_7_0,
  input  logic [7:0]  en_reg_pwm_15_8,
  input  logic [7:0]  pwm_duty_cycle,
  output logic [15:0] out
);

  localparam logic [DIV_W-1:0] PRE_LAST = DIV_W'(CLK_DIV - 1);

  logic [39:0]      bus_s;
  logic [39:0]      sync1_r;
  logic [39:0]      sync2_r;
  logic [39:0]      cfg_r;
  logic [39:0]      cfg_next_s;
  logic [DIV_W-1:0] pre_r;
  logic [7:0]       cnt_r;
  logic             tick_s;
  logic             wrap_s;
  logic [7:0]       duty_act_s;
  logic             pwm_sig_s;
  logic [15:0]      en_out_s;
  logic [15:0]      en_pwm_s;
  logic [15:0]      out_next_s;
  logic [15:0]      out_r;

  // Output enable dominates; PWM mode selects the shared waveform over static high.
  function automatic logic pin_drive(input logic en_o, input logic en_p, input logic pwm);
    logic drv;
    if (en_o) begin
      drv = en_p ? pwm : 1'b1;
    end else begin
      drv = 1'b0;
    end
    return drv;
  endfunction

  assign bus_s    = {en_reg_out_15_8, en_reg_out_7_0, en_reg_pwm_15_8, en_reg_pwm_7_0, pwm_duty_cycle};
  assign en_out_s = cfg_r[39:24];
  assign en_pwm_s = cfg_r[23:8];
  assign tick_s   = (pre_r == PRE_LAST);
  assign wrap_s   = tick_s && (cnt_r == 8'hFF);

  // Stability filter: accept the resynchronised bus only after two equal samples.
  always_comb begin
    cfg_next_s = cfg_r;
    if (sync1_r == sync2_r) begin
      cfg_next_s = sync2_r;
    end else begin
      cfg_next_s = cfg_r;
    end
  end

  // Two-flop resynchroniser and filtered config register.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_r <= 40'h00_0000_0000;
      sync2_r <= 40'h00_0000_0000;
      cfg_r   <= 40'h00_0000_0000;
    end else begin
      sync1_r <= bus_s;
      sync2_r <= sync1_r;
      cfg_r   <= cfg_next_s;
    end
  end

  // Prescaler producing one tick every CLK_DIV clocks.
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_r <= '0;
    end else if (tick_s) begin
      pre_r <= '0;
    end else begin
      pre_r <= pre_r + DIV_W'(1);
    end
  end

  // 256-tick period counter; wraps naturally from 255 to 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= 8'h00;
    end else if (tick_s) begin
      cnt_r <= cnt_r + 8'h01;
    end else begin
      cnt_r <= cnt_r;
    end
  end

`ifdef PWM_SHADOW_EN
  logic [7:0] duty_sh_r;

  // Shadow duty loads at wrap from the incoming config so a coincident update lands on cnt=0.
  always_ff @(posedge clk) begin
    if (rst) begin
      duty_sh_r <= 8'h00;
    end else if (wrap_s) begin
      duty_sh_r <= cfg_next_s[7:0];
    end else begin
      duty_sh_r <= duty_sh_r;
    end
  end

  assign duty_act_s = duty_sh_r;
`else
  logic unused_wrap_s;

  assign unused_wrap_s = wrap_s;
  assign duty_act_s    = cfg_r[7:0];
`endif

  // Duty compare; 0xFF is forced high so full duty never drops a tick.
  always_comb begin
    pwm_sig_s = 1'b0;
    if (duty_act_s == 8'hFF) begin
      pwm_sig_s = 1'b1;
    end else begin
      pwm_sig_s = (cnt_r < duty_act_s);
    end
  end

  // Per-pin drive selection.
  always_comb begin
    out_next_s = 16'h0000;
    for (int i = 0; i < 16; i++) begin
      out_next_s[i] = pin_drive(en_out_s[i], en_pwm_s[i], pwm_sig_s);
    end
  end

  // Registered pin outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_r <= 16'h0000;
    end else begin
      out_r <= out_next_s;
    end
  end

  assign out = out_r;

endmodule

// File: tb/tb_pwm_peripheral.sv
// Directed self-checking bench for pwm_peripheral (CLK_DIV=13, 3328 clk per PWM period).
module tb_pwm_peripheral;

  logic        clk;
  logic        rst;
  logic [7:0]  en_reg_out_7_0;
  logic [7:0]  en_reg_out_15_8;
  logic [7:0]  en_reg_pwm_7_0;
  logic [7:0]  en_reg_pwm_15_8;
  logic [7:0]  pwm_duty_cycle;
  logic [15:0] out;

  int checks;
  int failures;
  int ecount;

  pwm_peripheral #(.CLK_DIV(13), .DIV_W(4)) dut (
    .clk             (clk),
    .rst             (rst),
    .en_reg_out_7_0  (en_reg_out_7_0),
    .en_reg_out_15_8 (en_reg_out_15_8),
    .en_reg_pwm_7_0  (en_reg_pwm_7_0),
    .en_reg_pwm_15_8 (en_reg_pwm_15_8),
    .pwm_duty_cycle  (pwm_duty_cycle),
    .out             (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Rising edges seen with reset low since the last reset.
  always @(posedge clk) begin
    if (rst) ecount <= 0;
    else     ecount <= ecount + 1;
  end

  task automatic set_bus(input logic [15:0] eo, input logic [15:0] ep, input logic [7:0] d);
    en_reg_out_15_8 = eo[15:8];
    en_reg_out_7_0  = eo[7:0];
    en_reg_pwm_15_8 = ep[15:8];
    en_reg_pwm_7_0  = ep[7:0];
    pwm_duty_cycle  = d;
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    rst = 1'b1;
    repeat (cycles) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset;
    set_bus(16'hFFFF, 16'hFFFF, 8'hFF);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (out !== 16'h0000) begin
      failures++; $display("FAIL reset_out: got %h want 0000", out);
    end
    checks++;
    if (dut.cnt_r !== 8'h00 || dut.pre_r !== 4'h0) begin
      failures++; $display("FAIL reset_cnt_pre: got cnt=%h pre=%h want 00/0", dut.cnt_r, dut.pre_r);
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (out !== 16'h0000) begin
      failures++; $display("FAIL reset_latency3: got %h want 0000", out);
    end
    @(negedge clk);
    checks++;
    if (out !== 16'hFFFF) begin
      failures++; $display("FAIL reset_latency4: got %h want ffff", out);
    end
  endtask

  task automatic test_static_high;
    int bad;
    set_bus(16'h0001, 16'h0000, 8'h00);
    do_reset(2);
    repeat (3) @(negedge clk);
    checks++;
    if (out !== 16'h0000) begin
      failures++; $display("FAIL static_clk3: got %h want 0000", out);
    end
    @(negedge clk);
    checks++;
    if (out !== 16'h0001) begin
      failures++; $display("FAIL static_clk4: got %h want 0001", out);
    end
    bad = 0;
    repeat (60) begin
      @(negedge clk);
      if (out !== 16'h0001) bad++;
    end
    checks++;
    if (bad !== 0) begin
      failures++; $display("FAIL static_hold: got %0d bad cycles want 0", bad);
    end
  endtask

  task automatic test_pwm_mix;
    int hi [4];
    int bad;
    set_bus(16'h00FF, 16'h000F, 8'h80);
    repeat (3400) @(negedge clk);
    for (int i = 0; i < 4; i++) hi[i] = 0;
    bad = 0;
    repeat (3328) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) if (out[i] === 1'b1) hi[i]++;
      if (out[15:4] !== 12'h00F) bad++;
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (hi[i] !== 1664) begin
        failures++; $display("FAIL pwm_high_pin%0d: got %0d want 1664", i, hi[i]);
      end
    end
    checks++;
    if (bad !== 0) begin
      failures++; $display("FAIL pwm_static_pins: got %0d bad cycles want 0", bad);
    end
  endtask

  task automatic test_duty_limits;
    int bad;
    set_bus(16'hFFFF, 16'hFFFF, 8'h00);
    repeat (3400) @(negedge clk);
    bad = 0;
    repeat (3328) begin
      @(negedge clk);
      if (out !== 16'h0000) bad++;
    end
    checks++;
    if (bad !== 0) begin
      failures++; $display("FAIL duty_00: got %0d nonzero cycles want 0", bad);
    end
    set_bus(16'hFFFF, 16'hFFFF, 8'hFF);
    repeat (3400) @(negedge clk);
    bad = 0;
    repeat (3400) begin
      @(negedge clk);
      if (out !== 16'hFFFF) bad++;
    end
    checks++;
    if (bad !== 0) begin
      failures++; $display("FAIL duty_ff: got %0d non-ffff cycles want 0", bad);
    end
  endtask

  task automatic test_duty_change;
    int e, c, d, bad, hi2, hi3, want2;
    logic [15:0] exp;
    set_bus(16'hFFFF, 16'hFFFF, 8'h40);
    do_reset(2);
    repeat (3328) @(negedge clk);
    bad = 0; hi2 = 0; hi3 = 0;
    repeat (6656) begin
      @(negedge clk);
      e = ecount;
      c = ((e - 1) / 13) % 256;
`ifdef PWM_SHADOW_EN
      d = (e > 6656) ? 192 : 64;
`else
      d = (e > 3747) ? 192 : 64;
`endif
      exp = (c < d) ? 16'hFFFF : 16'h0000;
      if (out !== exp) begin
        if (bad == 0) $display("FAIL duty_change_cycle: edge %0d got %h want %h", e, out, exp);
        bad++;
      end
      if (out[0] === 1'b1) begin
        if (e <= 6656) hi2++;
        else           hi3++;
      end
      if (e == 3744) set_bus(16'hFFFF, 16'hFFFF, 8'hC0);
    end
`ifdef PWM_SHADOW_EN
    want2 = 832;
`else
    want2 = 2496;
`endif
    checks++;
    if (bad !== 0) begin
      failures++; $display("FAIL duty_change_trace: got %0d bad cycles want 0", bad);
    end
    checks++;
    if (hi2 !== want2) begin
      failures++; $display("FAIL duty_change_period2: got %0d high want %0d", hi2, want2);
    end
    checks++;
    if (hi3 !== 2496) begin
      failures++; $display("FAIL duty_change_period3: got %0d high want 2496", hi3);
    end
  endtask

  task automatic test_back_to_back;
    int bad;
    set_bus(16'hFFFF, 16'h0000, 8'h00);
    repeat (10) @(negedge clk);
    checks++;
    if (out !== 16'hFFFF) begin
      failures++; $display("FAIL toggle_setup: got %h want ffff", out);
    end
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      if (k % 2 == 0) set_bus(16'h0000, 16'h0000, 8'h00);
      else            set_bus(16'h00FF, 16'h0000, 8'h00);
      @(negedge clk);
      if (out !== 16'hFFFF) bad++;
    end
    set_bus(16'hFFFF, 16'h0000, 8'h00);
    repeat (4) begin
      @(negedge clk);
      if (out !== 16'hFFFF) bad++;
    end
    checks++;
    if (bad !== 0) begin
      failures++; $display("FAIL toggle_filter: got %0d changed cycles want 0", bad);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (out !== 16'h0000) begin
      failures++; $display("FAIL midpulse_reset: got %h want 0000", out);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    set_bus(16'h0000, 16'h0000, 8'h00);
    test_reset();
    test_static_high();
    test_pwm_mix();
    test_duty_limits();
    test_duty_change();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
